// File: rtl/vc_switch_allocator.sv
// Round-robin read sequencer for the five VC buffers (N,S,E,W,L) of one input module.
// Tracks downstream credits per direction and presents each popped packet with valid/ready.
module vc_switch_allocator #(
    parameter int CREDITS = 32,
    parameter int CW      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  vc_empty,
    input  logic [4:0]  recv_full,
    input  logic [4:0]  credit_return,
    input  logic [63:0] vc_data,
    input  logic        out_ready,
    output logic        read_en,
    output logic [2:0]  rr_select,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [2:0]  out_dir,
    output logic [4:0]  credits_zero
);

    localparam logic [2:0]    DIR_IDLE = 3'b111;
    localparam logic [2:0]    DIR_L    = 3'd4;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] credit [5];
    logic [4:0]    eligible;
    logic [4:0]    grant_vec;
    logic [2:0]    last_grant;
    logic [2:0]    pick;

    // First eligible direction after 'last', wrapping L -> N; DIR_IDLE when none.
    function automatic logic [2:0] rr_pick(input logic [4:0] elig, input logic [2:0] last);
        logic [2:0] idx;
        rr_pick = DIR_IDLE;
        idx     = last;
        for (int k = 0; k < 5; k++) begin
            idx = (idx >= DIR_L) ? 3'd0 : idx + 3'd1;
            if (elig[idx] && rr_pick == DIR_IDLE)
                rr_pick = idx;
        end
    endfunction

    always_comb begin
        eligible     = '0;
        credits_zero = '0;
        for (int i = 0; i < 5; i++) begin
            eligible[i]     = !vc_empty[i] && !recv_full[i] && (credit[i] != '0);
            credits_zero[i] = (credit[i] == '0);
        end
    end

    assign pick = rr_pick(eligible, last_grant);

    // Acceptance in SEND drops back to IDLE, which re-arbitrates on its first cycle,
    // giving a 3-cycle minimum between grants.
    always_comb begin
        state_nxt = state;
        read_en   = 1'b0;
        rr_select = DIR_IDLE;
        case (state)
            IDLE: begin
                if (reset && pick != DIR_IDLE) begin
                    read_en   = 1'b1;
                    rr_select = pick;
                    state_nxt = FETCH;
                end
            end
            FETCH:   state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_vec = '0;
        if (read_en)
            grant_vec[rr_select] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= DIR_L;
        end else begin
            state <= state_nxt;
            if (read_en)
                last_grant <= rr_select;
        end
    end

    // Buffer read data arrives during FETCH; register it toward the crossbar.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dir   <= DIR_IDLE;
        end else if (state == FETCH) begin
            out_valid <= 1'b1;
            out_data  <= vc_data;
            out_dir   <= last_grant;
        end else if (state == SEND && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Simultaneous grant and return cancel; returns beyond CREDITS are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++)
                credit[i] <= CRED_MAX;
        end else begin
            for (int i = 0; i < 5; i++) begin
                case ({grant_vec[i], credit_return[i]})
                    2'b10:   credit[i] <= credit[i] - CW'(1);
                    2'b01:   if (credit[i] != CRED_MAX) credit[i] <= credit[i] + CW'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Scoreboard bench for vc_switch_allocator: stimulus queues expected grants and packets,
// a negedge monitor compares them against read_en/rr_select and accepted outputs.
module tb_vc_switch_allocator;

    logic        clk;
    logic        reset;
    logic [4:0]  vc_empty;
    logic [4:0]  recv_full;
    logic [4:0]  credit_return;
    logic [63:0] vc_data;
    logic        out_ready;
    logic        read_en;
    logic [2:0]  rr_select;
    logic        out_valid;
    logic [63:0] out_data;
    logic [2:0]  out_dir;
    logic [4:0]  credits_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [63:0] buf_data [5];
    logic [2:0]  grant_q [$];
    logic [2:0]  exp_dir_q [$];
    logic [63:0] exp_data_q [$];

    int   last_gcyc = 0;
    bit   gap_have  = 0;
    bit   gap_chk   = 0;
    bit   pend      = 0;
    int   pend_cyc  = 0;

    vc_switch_allocator #(.CREDITS(32), .CW(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .vc_empty      (vc_empty),
        .recv_full     (recv_full),
        .credit_return (credit_return),
        .vc_data       (vc_data),
        .out_ready     (out_ready),
        .read_en       (read_en),
        .rr_select     (rr_select),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_dir       (out_dir),
        .credits_zero  (credits_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input logic [2:0] d);
        grant_q.push_back(d);
        exp_dir_q.push_back(d);
        exp_data_q.push_back(buf_data[d]);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("reset_async_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        gap_have = 0;
    endtask

    // Buffer model: read data is presented only in the cycle after read_en.
    always begin
        logic       re_s;
        logic [2:0] sel_s;
        @(posedge clk);
        re_s  = read_en;
        sel_s = rr_select;
        #1;
        if (re_s && sel_s < 3'd5)
            vc_data = buf_data[sel_s];
        else
            vc_data = 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // Monitor: grant order, grant spacing, read_en->out_valid latency, accepted packets.
    always @(negedge clk) begin
        if (reset) begin
            if (pend && cyc == pend_cyc) begin
                check("read_to_valid_latency", {63'd0, out_valid}, 64'd1);
                pend = 0;
            end
            if (read_en) begin
                if (grant_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: rr_select=%0d, no grant expected", rr_select);
                end else begin
                    check("grant_dir", {61'd0, rr_select}, {61'd0, grant_q.pop_front()});
                end
                if (gap_chk && gap_have)
                    check("grant_gap", 64'(cyc - last_gcyc), 64'd3);
                last_gcyc = cyc;
                gap_have  = 1;
                pend      = 1;
                pend_cyc  = cyc + 2;
            end
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_packet: out_data=%0h out_dir=%0d", out_data, out_dir);
                end else begin
                    check("out_data", out_data, exp_data_q.pop_front());
                    check("out_dir", {61'd0, out_dir}, {61'd0, exp_dir_q.pop_front()});
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        vc_empty      = 5'h1F;
        recv_full     = 5'h00;
        credit_return = 5'h00;
        out_ready     = 1'b1;
        vc_data       = 64'h0;
        buf_data[0]   = 64'h0000_0000_0000_A5A5;
        buf_data[1]   = 64'h1111_2222_3333_4444;
        buf_data[2]   = 64'hE0E0_1234_5678_0002;
        buf_data[3]   = 64'h3030_CAFE_F00D_0003;
        buf_data[4]   = 64'h4040_0BAD_C0DE_0004;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_en", {63'd0, read_en}, 64'd0);
        check("rst_rr_select", {61'd0, rr_select}, 64'd7);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_dir", {61'd0, out_dir}, 64'd7);
        check("rst_credits_zero", {59'd0, credits_zero}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // All buffers empty: nothing moves.
        repeat (20) begin
            @(negedge clk);
            check("idle_quiet", {54'd0, read_en, rr_select, out_valid, credits_zero},
                  {54'd0, 1'b0, 3'b111, 1'b0, 5'b00000});
        end

        // Excess credit returns saturate at CREDITS.
        @(posedge clk);
        #1 credit_return = 5'h1F;
        repeat (3) @(posedge clk);
        #1 credit_return = 5'h00;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            check("credit_saturate", {58'd0, dut.credit[i]}, 64'd32);

        // Single N packet.
        @(posedge clk);
        #1;
        expect_pkt(3'd0);
        vc_empty = 5'b11110;
        @(posedge clk);
        #1 vc_empty = 5'h1F;
        repeat (6) @(posedge clk);
        check("n_only_drained", 64'(exp_data_q.size() + grant_q.size()), 64'd0);

        // All five requesting: N,S,E,W,L,N at 3-cycle spacing.
        pulse_reset();
        expect_pkt(3'd0);
        expect_pkt(3'd1);
        expect_pkt(3'd2);
        expect_pkt(3'd3);
        expect_pkt(3'd4);
        expect_pkt(3'd0);
        gap_chk  = 1;
        vc_empty = 5'b00000;
        repeat (16) @(posedge clk);
        #1 vc_empty = 5'h1F;
        repeat (6) @(posedge clk);
        gap_chk = 0;
        check("rr_all_drained", 64'(exp_data_q.size() + grant_q.size()), 64'd0);

        // E only: exactly 32 grants exhaust its credits, one return buys one more.
        pulse_reset();
        for (int k = 0; k < 32; k++)
            expect_pkt(3'd2);
        vc_empty = 5'b11011;
        repeat (110) @(posedge clk);
        @(negedge clk);
        check("e_exhausted_zero", {59'd0, credits_zero}, 64'b00100);
        check("e_exhausted_no_read", {63'd0, read_en}, 64'd0);
        check("e_32_grants", 64'(grant_q.size()), 64'd0);
        @(posedge clk);
        #1;
        expect_pkt(3'd2);
        credit_return = 5'b00100;
        @(posedge clk);
        #1 credit_return = 5'b00000;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("e_return_rezero", {59'd0, credits_zero}, 64'b00100);
        check("e_one_more_grant", 64'(exp_data_q.size() + grant_q.size()), 64'd0);
        @(posedge clk);
        #1 vc_empty = 5'h1F;

        // S blocked by recv_full, then released with the crossbar stalled.
        pulse_reset();
        vc_empty  = 5'b11101;
        recv_full = 5'b00010;
        repeat (10) begin
            @(negedge clk);
            check("s_blocked_full", {60'd0, read_en, rr_select}, {60'd0, 1'b0, 3'b111});
        end
        check("s_full_keeps_credit", {58'd0, dut.credit[1]}, 64'd32);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_pkt(3'd1);
        recv_full = 5'b00000;
        @(negedge clk);
        check("s_grant_now", {60'd0, read_en, rr_select}, {60'd0, 1'b1, 3'd1});
        @(posedge clk);
        #1 vc_empty = 5'h1F;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_data", out_data, buf_data[1]);
            check("stall_dir", {61'd0, out_dir}, 64'd1);
            check("stall_no_read", {63'd0, read_en}, 64'd0);
        end

        // Reset in the middle of SEND drops the packet and restores credits.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midsend_valid", {63'd0, out_valid}, 64'd0);
        check("midsend_dir", {61'd0, out_dir}, 64'd7);
        for (int i = 0; i < 5; i++)
            check("midsend_credit", {58'd0, dut.credit[i]}, 64'd32);
        exp_data_q.delete();
        exp_dir_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_quiet", {62'd0, out_valid, read_en}, 64'd0);
        check("final_queues", 64'(grant_q.size() + exp_data_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
